// File: rtl/apb_ctrl_regfile.sv
// rtl/apb_ctrl_regfile.sv - APB3 slave control/status register file
// Control regs, status words, sticky IRQs, start pulse, busy cycle counter.
module apb_ctrl_regfile #(
  parameter int          NUM_CTRL    = 4,
  parameter int          NUM_STAT    = 4,
  parameter int          NUM_IRQ     = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h5A5A5A5A
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PWDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [31:0]           PRDATA,
  output logic [32*NUM_CTRL-1:0] ctrl_out,
  input  logic [32*NUM_STAT-1:0] stat_in,
  input  logic [NUM_IRQ-1:0]    irq_set,
  input  logic                  busy,
  output logic                  start_pulse,
  output logic                  irq
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [5:0]           addr_q, addr_d;
  logic                 err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          ctrl_q [NUM_CTRL];
  logic [31:0]          ctrl_d [NUM_CTRL];
  logic [NUM_IRQ-1:0]   irq_stat_q, irq_stat_d;
  logic [NUM_IRQ-1:0]   irq_en_q, irq_en_d;
  logic [31:0]          count_q, count_d;
  logic                 start_q, start_d;

  logic [5:0]           word;
  logic                 setup;
  logic                 commit;
  logic                 dec_err;
  logic [31:0]          rd_mux;
  logic                 unused_paddr;

  assign word         = PADDR[7:2];
  assign unused_paddr = ^{PADDR[31:8], PADDR[1:0]};
  assign setup        = (state_q == S_IDLE) & PSEL & ~PENABLE;
  assign commit       = PREADY & PSEL & PENABLE & PWRITE & ~err_q;

  // Address decode and read mux, evaluated against the live setup-phase address
  always_comb begin
    rd_mux  = '0;
    dec_err = 1'b1;
    case (word)
      6'd0: begin rd_mux = ID_VALUE; dec_err = PWRITE; end
      6'd1: dec_err = 1'b0;
      6'd2: begin rd_mux[NUM_IRQ-1:0] = irq_stat_q; dec_err = 1'b0; end
      6'd3: begin rd_mux[NUM_IRQ-1:0] = irq_en_q; dec_err = 1'b0; end
      6'd4: begin rd_mux = count_q; dec_err = PWRITE; end
      default: ;
    endcase
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (word == 6'(8 + i)) begin
        rd_mux  = ctrl_q[i];
        dec_err = 1'b0;
      end
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (word == 6'(16 + j)) begin
        rd_mux  = stat_in[32*j +: 32];
        dec_err = PWRITE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (setup) state_d = S_ACCESS;
      S_ACCESS: if (!PSEL || (PENABLE && PREADY)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PREADY  = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    PSLVERR = PREADY & err_q;
    PRDATA  = rdata_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (setup) begin
      cnt_d   = 4'(WAIT_STATES);
      addr_d  = word;
      err_d   = dec_err;
      rdata_d = dec_err ? 32'd0 : rd_mux;
    end else if (state_q == S_ACCESS && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Register side effects; set beats W1C clear, counter clear beats increment
  always_comb begin
    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_d[i] = (commit && addr_q == 6'(8 + i)) ? PWDATA : ctrl_q[i];
    end
    irq_en_d   = (commit && addr_q == 6'd3) ? PWDATA[NUM_IRQ-1:0] : irq_en_q;
    irq_stat_d = irq_stat_q;
    if (commit && addr_q == 6'd2) irq_stat_d = irq_stat_q & ~PWDATA[NUM_IRQ-1:0];
    irq_stat_d = irq_stat_d | irq_set;
    count_d    = count_q;
    if (commit && addr_q == 6'd1 && PWDATA[1]) count_d = 32'd0;
    else if (busy && count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
    start_d    = commit && (addr_q == 6'd1) && PWDATA[0];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 6'd0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= 32'd0;
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      count_q    <= 32'd0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= ctrl_d[i];
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      count_q    <= count_d;
      start_q    <= start_d;
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
    assign ctrl_out[32*g +: 32] = ctrl_q[g];
  end

  assign start_pulse = start_q;
  assign irq         = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_apb_ctrl_regfile.sv
// tb/tb_apb_ctrl_regfile.sv - scoreboard bench for apb_ctrl_regfile
// Three instances with 0, 3 and 5 wait states share one APB bus, selected by psel.
module tb_apb_ctrl_regfile;

  logic         CLK, RESET;
  logic [31:0]  PADDR, PWDATA;
  logic         PENABLE, PWRITE;
  logic [127:0] stat_in;
  logic [7:0]   irq_set;
  logic         busy;

  logic         psel   [3];
  logic         ready  [3];
  logic         slverr [3];
  logic [31:0]  rdata  [3];
  logic [127:0] ctrl   [3];
  logic         start  [3];
  logic         irqo   [3];

  typedef struct {
    int          dut;
    logic [31:0] rd;
    logic        err;
    logic        ck;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  apb_ctrl_regfile #(.WAIT_STATES(0)) u_w0 (
    .CLK(CLK), .RESET(RESET), .PADDR(PADDR), .PSEL(psel[0]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(ready[0]), .PSLVERR(slverr[0]),
    .PRDATA(rdata[0]), .ctrl_out(ctrl[0]), .stat_in(stat_in), .irq_set(irq_set),
    .busy(busy), .start_pulse(start[0]), .irq(irqo[0]));

  apb_ctrl_regfile #(.WAIT_STATES(3)) u_w3 (
    .CLK(CLK), .RESET(RESET), .PADDR(PADDR), .PSEL(psel[1]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(ready[1]), .PSLVERR(slverr[1]),
    .PRDATA(rdata[1]), .ctrl_out(ctrl[1]), .stat_in(stat_in), .irq_set(irq_set),
    .busy(busy), .start_pulse(start[1]), .irq(irqo[1]));

  apb_ctrl_regfile #(.WAIT_STATES(5)) u_w5 (
    .CLK(CLK), .RESET(RESET), .PADDR(PADDR), .PSEL(psel[2]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(ready[2]), .PSLVERR(slverr[2]),
    .PRDATA(rdata[2]), .ctrl_out(ctrl[2]), .stat_in(stat_in), .irq_set(irq_set),
    .busy(busy), .start_pulse(start[2]), .irq(irqo[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed transfer of any instance
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (psel[i] && PENABLE && ready[i]) begin
        if (sbq.size() == 0) begin
          chk("unexpected_completion", 128'(i), 128'hFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("mon_dut", 128'(i), 128'(e.dut));
          chk("mon_pslverr", {127'd0, slverr[i]}, {127'd0, e.err});
          if (e.ck) chk("mon_prdata", {96'd0, rdata[i]}, {96'd0, e.rd});
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge following completion
  task automatic apb(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [31:0] erd, input logic eerr, input logic ck, input int ewait);
    exp_t e;
    int   n;
    e.dut = d; e.rd = erd; e.err = eerr; e.ck = ck;
    sbq.push_back(e);
    psel[d] = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = wd;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    n = 0;
    forever begin
      @(negedge CLK);
      if (ready[d]) break;
      n++;
      if (n > 40) break;
    end
    chk("wait_cycles", 128'(n), 128'(ewait));
    @(posedge CLK); #1;
    psel[d] = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; PADDR = '0; PWDATA = '0; PENABLE = 1'b0; PWRITE = 1'b0;
    irq_set = '0; busy = 1'b0;
    stat_in = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_pready", {127'd0, ready[0]}, 128'd0);
    chk("rst_pslverr", {127'd0, slverr[0]}, 128'd0);
    chk("rst_prdata", {96'd0, rdata[0]}, 128'd0);
    chk("rst_ctrl", ctrl[0], 128'd0);
    chk("rst_start", {127'd0, start[0]}, 128'd0);
    chk("rst_irq", {127'd0, irqo[0]}, 128'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    apb(0, 32'h00, 0, 0, 32'h5A5A5A5A, 0, 1, 0);
    apb(1, 32'h00, 0, 0, 32'h5A5A5A5A, 0, 1, 3);
    apb(0, 32'hFFFFFF00, 0, 0, 32'h5A5A5A5A, 0, 1, 0);

    apb(0, 32'h24, 1, 32'h12345678, 0, 0, 0, 0);
    apb(0, 32'h24, 0, 0, 32'h12345678, 0, 1, 0);
    chk("ctrl1_out", {96'd0, ctrl[0][63:32]}, 128'h12345678);
    chk("ctrl_others", {ctrl[0][127:64], 32'd0, ctrl[0][31:0]}, 128'd0);
    apb(0, 32'h2C, 1, 32'hA5A5F00F, 0, 0, 0, 0);
    apb(0, 32'h2C, 0, 0, 32'hA5A5F00F, 0, 1, 0);
    apb(0, 32'h30, 0, 0, 32'h0, 1, 1, 0);

    apb(0, 32'h60, 0, 0, 32'h0, 1, 1, 0);
    apb(0, 32'h10, 1, 32'h0C, 32'h0, 1, 1, 0);
    apb(0, 32'h10, 0, 0, 32'h0, 0, 1, 0);
    apb(0, 32'h00, 1, 32'h1, 32'h0, 1, 1, 0);
    apb(0, 32'h4C, 0, 0, 32'hCAFE0003, 0, 1, 0);
    apb(0, 32'h40, 0, 0, 32'hCAFE0000, 0, 1, 0);
    apb(0, 32'h40, 1, 32'h1, 32'h0, 1, 1, 0);
    apb(0, 32'h50, 0, 0, 32'h0, 1, 1, 0);

    irq_set = 8'h04;
    @(posedge CLK); #1;
    irq_set = 8'h00;
    apb(0, 32'h0C, 1, 32'h04, 0, 0, 0, 0);
    chk("irq_enabled", {127'd0, irqo[0]}, 128'd1);
    apb(0, 32'h08, 0, 0, 32'h04, 0, 1, 0);
    irq_set = 8'h04;
    apb(0, 32'h08, 1, 32'h04, 0, 0, 0, 0);
    irq_set = 8'h00;
    apb(0, 32'h08, 0, 0, 32'h04, 0, 1, 0);
    apb(0, 32'h08, 1, 32'h04, 0, 0, 0, 0);
    apb(0, 32'h08, 0, 0, 32'h00, 0, 1, 0);
    chk("irq_cleared", {127'd0, irqo[0]}, 128'd0);
    apb(0, 32'h0C, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
    apb(0, 32'h0C, 0, 0, 32'h000000FF, 0, 1, 0);

    apb(0, 32'h04, 1, 32'h1, 0, 0, 0, 0);
    chk("start_high", {127'd0, start[0]}, 128'd1);
    @(posedge CLK); #1;
    chk("start_one_cycle", {127'd0, start[0]}, 128'd0);
    apb(0, 32'h04, 0, 0, 32'h0, 0, 1, 0);
    apb(0, 32'h04, 1, 32'h0, 0, 0, 0, 0);
    chk("start_none", {127'd0, start[0]}, 128'd0);

    busy = 1'b1;
    repeat (10) @(posedge CLK);
    #1 busy = 1'b0;
    apb(0, 32'h10, 0, 0, 32'd10, 0, 1, 0);
    busy = 1'b1;
    apb(0, 32'h04, 1, 32'h2, 0, 0, 0, 0);
    apb(0, 32'h10, 0, 0, 32'd0, 0, 1, 0);
    busy = 1'b0;
    apb(0, 32'h10, 0, 0, 32'd2, 0, 1, 0);

    // Abandon an in-flight write on the 5-wait-state instance with reset
    psel[2] = 1'b1; PENABLE = 1'b0; PADDR = 32'h20; PWRITE = 1'b1; PWDATA = 32'hDEADBEEF;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("w5_waiting", {127'd0, ready[2]}, 128'd0);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid_pready", {127'd0, ready[2]}, 128'd0);
    chk("rst_mid_ctrl0", {96'd0, ctrl[2][31:0]}, 128'd0);
    @(posedge CLK); #1;
    RESET = 1'b0; psel[2] = 1'b0; PENABLE = 1'b0;
    @(negedge CLK);
    chk("post_rst_ctrl0", {96'd0, ctrl[2][31:0]}, 128'd0);
    chk("post_rst_pready", {127'd0, ready[2]}, 128'd0);
    @(posedge CLK); #1;
    apb(2, 32'h20, 1, 32'h00000011, 0, 0, 0, 5);
    apb(2, 32'h20, 0, 0, 32'h00000011, 0, 1, 5);
    chk("post_rst_ctrl0_written", {96'd0, ctrl[2][31:0]}, 128'h11);

    repeat (2) @(posedge CLK);
    chk("scoreboard_drained", 128'(sbq.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=0", 1);
    $fatal(1);
  end

endmodule
